// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character-stream writer into a scrolling text RAM with a registered cell read port
module text_console_writer #(
    parameter int COLS     = 160,
    parameter int ROWS     = 45,
    parameter int NUM_CHAR = 256,
    parameter logic [$clog2(NUM_CHAR)-1:0] BLANK_CHAR = 'h20
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [$clog2(NUM_CHAR)-1:0] i_char,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [$clog2(COLS)-1:0]     i_rd_col,
    input  logic [$clog2(ROWS)-1:0]     i_rd_row,
    output logic [$clog2(NUM_CHAR)-1:0] o_rd_char,
    output logic [$clog2(COLS)-1:0]     o_cur_col,
    output logic [$clog2(ROWS)-1:0]     o_cur_row,
    output logic                        o_busy
);
    localparam int CW    = $clog2(NUM_CHAR);
    localparam int COLW  = $clog2(COLS);
    localparam int ROWW  = $clog2(ROWS);
    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [COLW-1:0] LAST_COL  = COLW'(COLS - 1);
    localparam logic [ROWW-1:0] LAST_ROW  = ROWW'(ROWS - 1);
    localparam logic [AW-1:0]   LAST_CELL = AW'(CELLS - 1);

    localparam logic [CW-1:0] CH_BS = CW'(8'h08);
    localparam logic [CW-1:0] CH_LF = CW'(8'h0A);
    localparam logic [CW-1:0] CH_FF = CW'(8'h0C);
    localparam logic [CW-1:0] CH_CR = CW'(8'h0D);

    typedef enum logic [1:0] {
        S_CLEAR_ALL,
        S_IDLE,
        S_CLEAR_LINE
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic [ROWW-1:0] top_q, top_d;
    logic [ROWW-1:0] line_q, line_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic [COLW-1:0] clr_col_q, clr_col_d;
    logic [CW-1:0]   rd_char_q, rd_char_d;

    logic            new_line;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [CW-1:0]   wdata;
    logic [ROWW-1:0] cur_prow;
    logic [ROWW-1:0] rd_prow;
    logic [AW-1:0]   rd_addr;

    logic [CW-1:0]   mem [CELLS];

    // Logical-to-physical row mapping with an explicit wrap, since ROWS is rarely a power of two.
    function automatic logic [ROWW-1:0] phys_row(input logic [ROWW-1:0] lrow,
                                                 input logic [ROWW-1:0] top);
        logic [ROWW:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= (ROWW+1)'(ROWS))
            sum = sum - (ROWW+1)'(ROWS);
        return sum[ROWW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [ROWW-1:0] prow,
                                                input logic [COLW-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        top_d      = top_q;
        line_d     = line_q;
        clr_addr_d = clr_addr_q;
        clr_col_d  = clr_col_q;
        new_line   = 1'b0;
        cur_prow   = phys_row(row_q, top_q);
        we         = 1'b0;
        waddr      = cell_addr(cur_prow, col_q);
        wdata      = BLANK_CHAR;

        case (state_q)
            S_CLEAR_ALL: begin
                we    = 1'b1;
                waddr = clr_addr_q;
                if (clr_addr_q == LAST_CELL) begin
                    clr_addr_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            S_CLEAR_LINE: begin
                we    = 1'b1;
                waddr = cell_addr(line_q, clr_col_q);
                if (clr_col_q == LAST_COL) begin
                    clr_col_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_col_d = clr_col_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (i_valid && ready_q) begin
                    case (i_char)
                        CH_LF: begin
                            col_d    = '0;
                            new_line = 1'b1;
                        end
                        CH_CR: col_d = '0;
                        CH_BS: begin
                            if (col_q != '0) begin
                                col_d = col_q - 1'b1;
                                we    = 1'b1;
                                waddr = cell_addr(cur_prow, col_q - 1'b1);
                            end
                        end
                        CH_FF: begin
                            top_d      = '0;
                            col_d      = '0;
                            row_d      = '0;
                            clr_addr_d = '0;
                            state_d    = S_CLEAR_ALL;
                        end
                        default: begin
                            we    = 1'b1;
                            wdata = i_char;
                            if (col_q == LAST_COL) begin
                                col_d    = '0;
                                new_line = 1'b1;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_CLEAR_ALL;
        endcase

        // At the bottom row a new line scrolls: the old top row becomes the fresh bottom row.
        if (new_line) begin
            if (row_q != LAST_ROW) begin
                row_d = row_q + 1'b1;
            end else begin
                line_d    = top_q;
                top_d     = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
                clr_col_d = '0;
                state_d   = S_CLEAR_LINE;
            end
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);

        rd_prow = phys_row(i_rd_row, top_q);
        rd_addr = cell_addr(rd_prow, i_rd_col);
        rd_char_d = (32'(rd_addr) < 32'(CELLS)) ? mem[rd_addr] : BLANK_CHAR;
    end

    always_ff @(posedge i_clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_CLEAR_ALL;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            top_q      <= '0;
            line_q     <= '0;
            clr_addr_q <= '0;
            clr_col_q  <= '0;
            rd_char_q  <= BLANK_CHAR;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            col_q      <= col_d;
            row_q      <= row_d;
            top_q      <= top_d;
            line_q     <= line_d;
            clr_addr_q <= clr_addr_d;
            clr_col_q  <= clr_col_d;
            rd_char_q  <= rd_char_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_busy    = busy_q;
    assign o_cur_col = col_q;
    assign o_cur_row = row_q;
    assign o_rd_char = rd_char_q;
endmodule
